// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: funct3 decode, taken decision, registered PC redirect and flushes.
// Optional statistics counters are built only when BRANCH_RESOLVE_STATS_EN is defined.
module branch_resolve_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  ex_valid,
   input  logic                  ex_branch,
   input  logic                  ex_jump,
   input  logic [2:0]            ex_funct3,
   input  logic [ADDR_WIDTH-1:0] ex_target,
   input  logic                  br_eq,
   input  logic                  br_lt,
   output logic                  br_un,
   output logic                  redirect_valid,
   output logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  flush_if_id,
   output logic                  flush_id_ex,
   output logic                  illegal_br,
   output logic [CNT_WIDTH-1:0]  branch_cnt,
   output logic [CNT_WIDTH-1:0]  taken_cnt
);

   typedef enum logic {IDLE, REDIRECT} stateT;

   stateT state;
   logic  condTaken;
   logic  funct3Illegal;
   logic  activeNow;
   logic  takenNow;
   logic  illegalNow;
   logic  resolveNow;
   logic  unusedTargetBits;

   assign br_un = (ex_funct3 == 3'b110) || (ex_funct3 == 3'b111);

   always_comb begin
      condTaken     = 1'b0;
      funct3Illegal = 1'b0;
      case (ex_funct3)
         3'b000:         condTaken = br_eq;
         3'b001:         condTaken = !br_eq;
         3'b100, 3'b110: condTaken = br_lt;
         3'b101, 3'b111: condTaken = !br_lt;
         default:        funct3Illegal = 1'b1;
      endcase
   end

   // Anything reaching EX while a redirect is pending is wrong-path and is ignored.
   assign activeNow  = ex_valid && (state == IDLE) && !stall;
   assign takenNow   = activeNow && (ex_jump || (ex_branch && condTaken));
   assign illegalNow = activeNow && ex_branch && !ex_jump && funct3Illegal;
   assign resolveNow = activeNow && (ex_branch || ex_jump);

   assign unusedTargetBits = ^ex_target[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         flush_if_id    <= 1'b0;
         flush_id_ex    <= 1'b0;
         illegal_br     <= 1'b0;
      end else if (!stall) begin
         illegal_br <= illegalNow;
         case (state)
            IDLE: begin
               if (takenNow) begin
                  state          <= REDIRECT;
                  redirect_valid <= 1'b1;
                  flush_if_id    <= 1'b1;
                  flush_id_ex    <= 1'b1;
                  redirect_pc    <= {ex_target[ADDR_WIDTH-1:2], 2'b00};
               end else begin
                  redirect_valid <= 1'b0;
                  flush_if_id    <= 1'b0;
                  flush_id_ex    <= 1'b0;
               end
            end
            REDIRECT: begin
               state          <= IDLE;
               redirect_valid <= 1'b0;
               flush_if_id    <= 1'b0;
               flush_id_ex    <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end else begin
         // A stall freezes a pending redirect but never stretches the illegal pulse.
         illegal_br <= 1'b0;
      end
   end

`ifdef BRANCH_RESOLVE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt <= '0;
         taken_cnt  <= '0;
      end else begin
         if (resolveNow) branch_cnt <= branch_cnt + CNT_WIDTH'(1);
         if (takenNow)   taken_cnt  <= taken_cnt + CNT_WIDTH'(1);
      end
   end
`else
   logic unusedResolve;
   assign unusedResolve = resolveNow;
   assign branch_cnt    = '0;
   assign taken_cnt     = '0;
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
EX-stage branch resolution block, directly downstream of the branch comparator. It decodes funct3 and drives the comparator's signedness select. It combines the equality/less-than flags into a taken decision and registers a PC redirect. It also generates pipeline flushes and suppresses the one wrong-path instruction that reaches EX during the redirect cycle.

Parameters:
ADDR_WIDTH, 32, width of PC and target addresses
CNT_WIDTH, 32, width of statistics counters (optional feature only)

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  pipeline hold; no state advance or capture while 1
ex_valid  in  1  EX holds a valid instruction
ex_branch  in  1  EX instruction is a conditional branch
ex_jump  in  1  EX instruction is JAL/JALR (unconditional)
ex_funct3  in  3  branch funct3
ex_target  in  ADDR_WIDTH  computed branch/jump target
br_eq  in  1  equality flag from comparator
br_lt  in  1  less-than flag from comparator
br_un  out  1  comparator select: 1 = unsigned compare, 0 = signed (combinational)
redirect_valid  out  1  registered; PC mux selects redirect_pc
redirect_pc  out  ADDR_WIDTH  registered redirect target, word-aligned
flush_if_id  out  1  registered; squash IF/ID register
flush_id_ex  out  1  registered; squash ID/EX register
illegal_br  out  1  registered one-cycle pulse on invalid branch funct3
branch_cnt  out  CNT_WIDTH  resolved-branch count (optional feature)
taken_cnt  out  CNT_WIDTH  taken-branch/jump count (optional feature)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; redirect_valid, flush_if_id, flush_id_ex, illegal_br, redirect_pc, counters all 0.
- br_un = 1 when ex_funct3 is 110 (BLTU) or 111 (BGEU); 0 otherwise. Combinational and independent of state.
- Taken decode for an active instruction, i.e. ex_valid=1 and state=IDLE:
  - ex_jump=1 -> taken, regardless of ex_branch or funct3.
  - Otherwise, with ex_branch=1:
    - 000 BEQ: br_eq
    - 001 BNE: !br_eq
    - 100 BLT and 110 BLTU: br_lt
    - 101 BGE and 111 BGEU: !br_lt
    - 010 or 011: not taken; illegal_br pulses high for 1 cycle.
- FSM states: IDLE, REDIRECT.
  - IDLE, stall=0, taken -> REDIRECT.
    - Next edge: redirect_valid=1, flush_if_id=1, flush_id_ex=1.
    - redirect_pc = {ex_target[ADDR_WIDTH-1:2], 2'b00}.
  - IDLE, not taken or stall=1 -> stay IDLE. All pulse outputs 0; no capture while stalled.
  - REDIRECT, stall=0 -> IDLE. redirect_valid and flushes drop next edge.
  - REDIRECT, stall=1 -> hold REDIRECT; redirect_valid, flushes and redirect_pc stay constant.
- Wrong-path suppression: in REDIRECT, ex_valid/ex_branch/ex_jump are ignored. No decision, no illegal_br, no count.
  - Consequence: back-to-back taken branches cannot both redirect; the second is wrong-path by construction.
- Latency: 1 cycle from EX decision to redirect_valid. Exactly 2 wrong-path instructions flushed per taken event.
- ex_branch=1 and ex_jump=1 together: treated as jump (taken); counted as one branch.
- Mid-operation reset: rst_n low in REDIRECT clears all outputs immediately; no redirect is issued after release.

Optional Feature:
Macro BRANCH_RESOLVE_STATS_EN.
- Defined:
  - branch_cnt increments on every active (IDLE, stall=0, ex_valid=1) branch or jump resolution, illegal ones included.
  - taken_cnt increments on every taken event.
  - Both wrap modulo 2^CNT_WIDTH and are cleared by reset.
- Undefined: ports still exist, tied to 0, no counter flops.

Test Plan:
- BEQ, funct3=000, br_eq=1, ex_target=0x0000_1006, stall=0 -> next cycle redirect_valid=1, redirect_pc=0x0000_1004, both flushes=1 for exactly 1 cycle.
- BNE, funct3=001, br_eq=1 -> no redirect, flushes 0, state stays IDLE; br_un=0.
- BGEU, funct3=111, br_lt=0 -> br_un=1 combinationally; taken; redirect issued. Repeat with br_lt=1 -> not taken.
- Taken BLT, then stall=1 for 3 cycles in REDIRECT -> redirect_valid and flushes held 4 cycles total, redirect_pc unchanged. A valid jump presented during REDIRECT is ignored.
- funct3=010 with ex_branch=1 -> illegal_br high 1 cycle, no redirect. Assert rst_n=0 during REDIRECT -> all outputs 0 asynchronously.
- With BRANCH_RESOLVE_STATS_EN: 5 branches (3 taken) plus 1 jump, none wrong-path -> branch_cnt=6, taken_cnt=4. Without the macro -> both read 0.
